// File: rtl/spk_det_pkg.sv
// Shared definitions for the spike detector bank merge path: bank count,
// field widths and the queued event record.
package spk_det_pkg;

  localparam int NUM_BANK = 5;
  localparam int CH_W     = 12;
  localparam int DATA_W   = 32;
  localparam int HASH_W   = 32;
  localparam int BANK_W   = 3;
  localparam int EVT_W    = CH_W + DATA_W + HASH_W;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [HASH_W-1:0] hash;
  } spk_evt_t;

  localparam spk_evt_t EVT_ZERO = spk_evt_t'({EVT_W{1'b0}});

  // Round-robin successor of a bank index among n banks.
  function automatic logic [BANK_W-1:0] rr_next(input logic [BANK_W-1:0] idx, input int n);
    rr_next = (int'(idx) >= n - 1) ? {BANK_W{1'b0}} : idx + BANK_W'(1'b1);
  endfunction

endpackage

// File: rtl/spk_bank_fifo.sv
// One detector bank's event queue: circular storage with wrapping pointers
// and an occupancy count that drives the full/empty flags.
module spk_bank_fifo
  import spk_det_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  spk_evt_t wr_evt,
  output spk_evt_t rd_evt,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          wr_en_s, rd_en_s;
  spk_evt_t      mem_q [DEPTH];

  assign full   = (occ_q == (AW+1)'(DEPTH));
  assign empty  = (occ_q == {(AW+1){1'b0}});
  assign rd_en_s = pop & ~empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign wr_en_s = push & (~full | rd_en_s);
  assign rd_evt  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   occ_d = occ_q + (AW+1)'(1'b1);
      2'b01:   occ_d = occ_q - (AW+1)'(1'b1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_evt;
    end
  end

endmodule

// File: rtl/spk_bank_arb.sv
// Merges peak events from all detector banks into one valid/ready stream:
// per-bank queues, round-robin grant into an output register, drop counters.
module spk_bank_arb #(
  parameter int NUM_BANK   = spk_det_pkg::NUM_BANK,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      bus_clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic                      muap_comb_valid,
  input  logic [NUM_BANK-1:0]       muap_is_peak,
  input  logic [12*NUM_BANK-1:0]    muap_comb_ch,
  input  logic [32*NUM_BANK-1:0]    muap_comb_data,
  input  logic [32*NUM_BANK-1:0]    muap_comb_ch_hash,
  output logic                      spk_valid,
  input  logic                      spk_ready,
  output logic [2:0]                spk_bank,
  output logic [11:0]               spk_ch,
  output logic [31:0]               spk_data,
  output logic [31:0]               spk_hash,
  output logic [NUM_BANK-1:0]       fifo_full,
  input  logic                      drop_clr,
  output logic [CNT_W*NUM_BANK-1:0] drop_cnt_comb
);

  import spk_det_pkg::*;

  spk_evt_t            push_evt_s [NUM_BANK];
  spk_evt_t            head_evt_s [NUM_BANK];
  logic [NUM_BANK-1:0] push_s, pop_s, empty_s, full_s, drop_s;
  logic                load_s, grant_found_s;
  logic [BANK_W-1:0]   grant_idx_s, cand_s;
  logic [BANK_W:0]     sum_s;

  logic                spk_valid_q, spk_valid_d;
  logic [BANK_W-1:0]   spk_bank_q, spk_bank_d;
  logic [BANK_W-1:0]   rr_ptr_q, rr_ptr_d;
  spk_evt_t            out_evt_q, out_evt_d;
  logic [CNT_W-1:0]    drop_cnt_q [NUM_BANK];
  logic [CNT_W-1:0]    drop_cnt_d [NUM_BANK];

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign push_evt_s[b] = {muap_comb_ch[CH_W*b +: CH_W],
                            muap_comb_data[DATA_W*b +: DATA_W],
                            muap_comb_ch_hash[HASH_W*b +: HASH_W]};
    assign push_s[b] = arb_en & muap_comb_valid & muap_is_peak[b];
    assign drop_s[b] = push_s[b] & full_s[b] & ~pop_s[b];
    assign drop_cnt_comb[CNT_W*b +: CNT_W] = drop_cnt_q[b];

    spk_bank_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk    (bus_clk),
      .rst    (rst),
      .push   (push_s[b]),
      .pop    (pop_s[b]),
      .wr_evt (push_evt_s[b]),
      .rd_evt (head_evt_s[b]),
      .full   (full_s[b]),
      .empty  (empty_s[b])
    );
  end

  assign fifo_full = full_s;
  assign load_s    = ~spk_valid_q | spk_ready;
  assign spk_valid = spk_valid_q;
  assign spk_bank  = spk_bank_q;
  assign spk_ch    = out_evt_q.ch;
  assign spk_data  = out_evt_q.data;
  assign spk_hash  = out_evt_q.hash;

  // First non-empty bank starting at rr_ptr, then pop it if the output loads.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {BANK_W{1'b0}};
    sum_s         = {(BANK_W+1){1'b0}};
    cand_s        = {BANK_W{1'b0}};
    pop_s         = {NUM_BANK{1'b0}};
    for (int i = 0; i < NUM_BANK; i++) begin
      sum_s  = {1'b0, rr_ptr_q} + (BANK_W+1)'(i);
      cand_s = (sum_s >= (BANK_W+1)'(NUM_BANK)) ? BANK_W'(sum_s - (BANK_W+1)'(NUM_BANK))
                                                : sum_s[BANK_W-1:0];
      grant_idx_s   = (!grant_found_s && !empty_s[cand_s]) ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | ~empty_s[cand_s];
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      pop_s[b] = load_s & grant_found_s & (grant_idx_s == BANK_W'(b));
    end
  end

  // Output register and round-robin pointer; an empty load keeps the old payload.
  always_comb begin
    spk_valid_d = spk_valid_q;
    spk_bank_d  = spk_bank_q;
    out_evt_d   = out_evt_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_s) begin
      if (grant_found_s) begin
        spk_valid_d = 1'b1;
        spk_bank_d  = grant_idx_s;
        out_evt_d   = head_evt_s[grant_idx_s];
        rr_ptr_d    = rr_next(grant_idx_s, NUM_BANK);
      end else begin
        spk_valid_d = 1'b0;
      end
    end else begin
      spk_valid_d = spk_valid_q;
    end
  end

  // Saturating drop counters; clear wins over a coincident drop.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      drop_cnt_d[b] = drop_cnt_q[b];
      if (drop_clr) begin
        drop_cnt_d[b] = {CNT_W{1'b0}};
      end else if (drop_s[b] && (drop_cnt_q[b] != {CNT_W{1'b1}})) begin
        drop_cnt_d[b] = drop_cnt_q[b] + CNT_W'(1'b1);
      end else begin
        drop_cnt_d[b] = drop_cnt_q[b];
      end
    end
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      spk_valid_q <= 1'b0;
      spk_bank_q  <= {BANK_W{1'b0}};
      rr_ptr_q    <= {BANK_W{1'b0}};
      out_evt_q   <= EVT_ZERO;
      for (int b = 0; b < NUM_BANK; b++) begin
        drop_cnt_q[b] <= {CNT_W{1'b0}};
      end
    end else begin
      spk_valid_q <= spk_valid_d;
      spk_bank_q  <= spk_bank_d;
      rr_ptr_q    <= rr_ptr_d;
      out_evt_q   <= out_evt_d;
      for (int b = 0; b < NUM_BANK; b++) begin
        drop_cnt_q[b] <= drop_cnt_d[b];
      end
    end
  end

endmodule

// File: tb/tb_spk_bank_arb.sv
// Directed and randomized bench for spk_bank_arb against a queue-based model.
module tb_spk_bank_arb;

  localparam int NB    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic            bus_clk = 1'b0;
  logic            rst = 1'b1;
  logic            arb_en = 1'b1;
  logic            mv = 1'b0;
  logic [NB-1:0]   peak = '0;
  logic [12*NB-1:0] ch_in = '0;
  logic [32*NB-1:0] data_in = '0;
  logic [32*NB-1:0] hash_in = '0;
  logic            ready = 1'b0;
  logic            drop_clr = 1'b0;
  logic            spk_valid;
  logic [2:0]      spk_bank;
  logic [11:0]     spk_ch;
  logic [31:0]     spk_data, spk_hash;
  logic [NB-1:0]   fifo_full;
  logic [CW*NB-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  spk_bank_arb #(.NUM_BANK(NB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .bus_clk(bus_clk), .rst(rst), .arb_en(arb_en), .muap_comb_valid(mv),
    .muap_is_peak(peak), .muap_comb_ch(ch_in), .muap_comb_data(data_in),
    .muap_comb_ch_hash(hash_in), .spk_valid(spk_valid), .spk_ready(ready),
    .spk_bank(spk_bank), .spk_ch(spk_ch), .spk_data(spk_data), .spk_hash(spk_hash),
    .fifo_full(fifo_full), .drop_clr(drop_clr), .drop_cnt_comb(drop_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: one queue per bank, a presented event and a rotation start.
  logic [75:0] mq [NB][$];
  bit          m_valid;
  int          m_bank, m_rr;
  logic [75:0] m_out;
  int          m_cnt [NB];

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      mq[b].delete();
      m_cnt[b] = 0;
    end
    m_valid = 0; m_bank = 0; m_rr = 0; m_out = '0;
  endfunction

  function automatic void model_step();
    int g;
    g = -1;
    if (!m_valid || ready) begin
      for (int k = 0; k < NB; k++)
        if (g < 0 && mq[(m_rr + k) % NB].size() > 0) g = (m_rr + k) % NB;
      if (g >= 0) begin
        m_out = mq[g].pop_front();
        m_bank = g; m_valid = 1; m_rr = (g + 1) % NB;
      end else begin
        m_valid = 0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (arb_en && mv && peak[b]) begin
        if (mq[b].size() < DEPTH)
          mq[b].push_back({ch_in[12*b +: 12], data_in[32*b +: 32], hash_in[32*b +: 32]});
        else if (m_cnt[b] < (1 << CW) - 1)
          m_cnt[b]++;
      end
    end
    if (drop_clr)
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
  endfunction

  function automatic logic [NB-1:0] exp_full();
    for (int b = 0; b < NB; b++) exp_full[b] = (mq[b].size() == DEPTH);
  endfunction

  function automatic logic [CW*NB-1:0] exp_cnt();
    for (int b = 0; b < NB; b++) exp_cnt[CW*b +: CW] = CW'(m_cnt[b]);
  endfunction

  task automatic tick();
    @(posedge bus_clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic idle();
    mv = 1'b0; peak = '0;
  endtask

  task automatic set_bank_event(input int b, input logic [11:0] c, input logic [31:0] d,
                                input logic [31:0] h);
    mv = 1'b1; peak[b] = 1'b1;
    ch_in[12*b +: 12] = c; data_in[32*b +: 32] = d; hash_in[32*b +: 32] = h;
  endtask

  task automatic set_frame(input logic [NB-1:0] pk);
    mv = 1'b1; peak = pk;
    for (int b = 0; b < NB; b++) begin
      ch_in[12*b +: 12] = 12'($urandom);
      data_in[32*b +: 32] = $urandom;
      hash_in[32*b +: 32] = $urandom;
    end
  endtask

  task automatic do_reset();
    idle(); drop_clr = 1'b0; arb_en = 1'b1;
    rst = 1'b1; model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    checks++;
    if (spk_valid !== 1'b0 || spk_bank !== 3'd0 || spk_ch !== 12'd0 || spk_data !== 32'd0 || spk_hash !== 32'd0)
      begin errors++; $display("FAIL reset_out got v=%b b=%0d ch=%h d=%h h=%h want all zero", spk_valid, spk_bank, spk_ch, spk_data, spk_hash); end
    checks++;
    if (fifo_full !== 5'b00000 || drop_cnt !== 40'd0)
      begin errors++; $display("FAIL reset_flags got full=%b cnt=%h want 0", fifo_full, drop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single_peak();
    do_reset(); ready = 1'b1;
    set_bank_event(2, 12'd5, 32'hFFFF_FF80, 32'h4);
    tick(); idle();
    checks++;
    if (spk_valid !== 1'b0) begin errors++; $display("FAIL single_early got v=%b want 0", spk_valid); end
    tick();
    checks++;
    if (spk_valid !== 1'b1 || spk_bank !== 3'd2 || spk_ch !== 12'd5 || spk_data !== 32'hFFFF_FF80 || spk_hash !== 32'h4)
      begin errors++; $display("FAIL single_out got v=%b b=%0d ch=%0d d=%h h=%h want 1/2/5/ffffff80/4", spk_valid, spk_bank, spk_ch, spk_data, spk_hash); end
    tick();
    checks++;
    if (spk_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got v=%b want 0", spk_valid); end
  endtask

  task automatic test_all_banks();
    int exp_seq [6] = '{0, 1, 2, 3, 4, 0};
    do_reset(); ready = 1'b1;
    set_frame(5'b11111);
    tick();
    set_frame(5'b00001);
    for (int i = 0; i < 6; i++) begin
      tick(); idle();
      checks++;
      if (spk_valid !== 1'b1 || spk_bank !== 3'(exp_seq[i]))
        begin errors++; $display("FAIL all_banks_order step=%0d got v=%b b=%0d want 1/%0d", i, spk_valid, spk_bank, exp_seq[i]); end
      checks++;
      if ({spk_ch, spk_data, spk_hash} !== m_out)
        begin errors++; $display("FAIL all_banks_payload step=%0d got %h want %h", i, {spk_ch, spk_data, spk_hash}, m_out); end
    end
    tick();
    checks++;
    if (spk_valid !== 1'b0) begin errors++; $display("FAIL all_banks_tail got v=%b want 0", spk_valid); end
  endtask

  task automatic test_full_drop();
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle(); set_bank_event(1, 12'(k), 32'h1000 + k, 32'(k)); tick();
    end
    idle();
    checks++;
    if (fifo_full !== 5'b00010) begin errors++; $display("FAIL full_flag got %b want 00010", fifo_full); end
    checks++;
    if (drop_cnt[CW*1 +: CW] !== 8'd1) begin errors++; $display("FAIL full_dropcnt got %0d want 1", drop_cnt[CW*1 +: CW]); end
    checks++;
    if (spk_valid !== 1'b1 || spk_data !== 32'h1000) begin errors++; $display("FAIL full_held got v=%b d=%h want 1/1000", spk_valid, spk_data); end
    ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      checks++;
      if (spk_valid !== 1'b1 || spk_bank !== 3'd1 || spk_data !== 32'h1000 + k)
        begin errors++; $display("FAIL full_drain k=%0d got v=%b b=%0d d=%h want 1/1/%h", k, spk_valid, spk_bank, spk_data, 32'h1000 + k); end
    end
    tick();
    checks++;
    if (spk_valid !== 1'b0 || fifo_full !== 5'b00000)
      begin errors++; $display("FAIL full_empty got v=%b full=%b want 0/00000", spk_valid, fifo_full); end
  endtask

  task automatic test_full_pushpop();
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 5; k++) begin set_frame(5'b01000); tick(); end
    checks++;
    if (fifo_full !== 5'b01000) begin errors++; $display("FAIL pushpop_fill got %b want 01000", fifo_full); end
    ready = 1'b1; set_frame(5'b01000);
    tick(); idle();
    checks++;
    if (fifo_full !== 5'b01000 || drop_cnt[CW*3 +: CW] !== 8'd0)
      begin errors++; $display("FAIL pushpop_same got full=%b cnt=%0d want 01000/0", fifo_full, drop_cnt[CW*3 +: CW]); end
    checks++;
    if (spk_valid !== 1'b1 || {spk_ch, spk_data, spk_hash} !== m_out)
      begin errors++; $display("FAIL pushpop_out got v=%b %h want 1/%h", spk_valid, {spk_ch, spk_data, spk_hash}, m_out); end
  endtask

  task automatic test_saturation();
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 265; k++) begin set_frame(5'b00001); tick(); end
    checks++;
    if (drop_cnt[CW-1:0] !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h want ff", drop_cnt[CW-1:0]); end
    drop_clr = 1'b1; set_frame(5'b00001);
    tick();
    drop_clr = 1'b0;
    checks++;
    if (drop_cnt[CW-1:0] !== 8'h00) begin errors++; $display("FAIL sat_clr got %h want 00", drop_cnt[CW-1:0]); end
    tick(); idle();
    checks++;
    if (drop_cnt[CW-1:0] !== 8'h01) begin errors++; $display("FAIL sat_restart got %h want 01", drop_cnt[CW-1:0]); end
  endtask

  task automatic test_arb_en();
    do_reset(); ready = 1'b1; arb_en = 1'b0;
    set_frame(5'b11111);
    tick(); tick();
    checks++;
    if (spk_valid !== 1'b0 || fifo_full !== 5'b00000)
      begin errors++; $display("FAIL arben_block got v=%b full=%b want 0/00000", spk_valid, fifo_full); end
    arb_en = 1'b1; set_frame(5'b10000);
    tick();
    arb_en = 1'b0; set_frame(5'b10000);
    tick(); idle();
    checks++;
    if (spk_valid !== 1'b1 || spk_bank !== 3'd4) begin errors++; $display("FAIL arben_drain got v=%b b=%0d want 1/4", spk_valid, spk_bank); end
    tick();
    checks++;
    if (spk_valid !== 1'b0) begin errors++; $display("FAIL arben_nopush got v=%b want 0", spk_valid); end
    arb_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset(); ready = 1'b0;
    for (int k = 0; k < 7; k++) begin set_frame(5'b11111); tick(); end
    idle();
    #2 rst = 1'b1; model_reset();
    #1;
    checks++;
    if (spk_valid !== 1'b0 || spk_bank !== 3'd0 || spk_ch !== 12'd0 || spk_data !== 32'd0 || spk_hash !== 32'd0)
      begin errors++; $display("FAIL midrst_out got v=%b b=%0d ch=%h d=%h h=%h want all zero", spk_valid, spk_bank, spk_ch, spk_data, spk_hash); end
    checks++;
    if (fifo_full !== 5'b00000 || drop_cnt !== 40'd0)
      begin errors++; $display("FAIL midrst_flags got full=%b cnt=%h want 0", fifo_full, drop_cnt); end
    tick();
    rst = 1'b0; ready = 1'b1;
    set_frame(5'b10100);
    tick(); idle();
    tick();
    checks++;
    if (spk_valid !== 1'b1 || spk_bank !== 3'd2)
      begin errors++; $display("FAIL midrst_first got v=%b b=%0d want 1/2", spk_valid, spk_bank); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      arb_en   = ($urandom_range(0, 9) != 0);
      ready    = ($urandom_range(0, 3) != 0);
      drop_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) set_frame(NB'($urandom)); else idle();
      tick();
      checks++;
      if (spk_valid !== m_valid || spk_bank !== 3'(m_bank) || {spk_ch, spk_data, spk_hash} !== m_out)
        begin errors++; $display("FAIL rnd_out cyc=%0d got v=%b b=%0d %h want v=%b b=%0d %h", c, spk_valid, spk_bank, {spk_ch, spk_data, spk_hash}, m_valid, m_bank, m_out); end
      checks++;
      if (fifo_full !== exp_full() || drop_cnt !== exp_cnt())
        begin errors++; $display("FAIL rnd_flags cyc=%0d got full=%b cnt=%h want full=%b cnt=%h", c, fifo_full, drop_cnt, exp_full(), exp_cnt()); end
    end
    drop_clr = 1'b0; idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_peak();
    test_all_banks();
    test_full_drop();
    test_full_pushpop();
    test_saturation();
    test_arb_en();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
